// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared types, constants and saturation helper for the equalizer band sequencer
package eq_pkg;

    localparam int DW        = 16;
    localparam int GAIN_FRAC = 14;
    localparam logic [DW-1:0] UNITY_GAIN = DW'(1) << GAIN_FRAC;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        MAC   = 3'd3,
        OUT   = 3'd4,
        WRITE = 3'd5
    } state_t;

    // Clamp a wide signed value into the signed DW-bit sample range.
    function automatic logic signed [DW-1:0] saturate(input logic signed [63:0] v);
        if (v > ((64'sd1 <<< (DW-1)) - 64'sd1)) begin
            saturate = {1'b0, {(DW-1){1'b1}}};
        end else if (v < -(64'sd1 <<< (DW-1))) begin
            saturate = {1'b1, {(DW-1){1'b0}}};
        end else begin
            saturate = v[DW-1:0];
        end
    endfunction

endpackage

// File: rtl/eq_gain_regfile.sv
// rtl/eq_gain_regfile.sv - per-band gain registers, reset to unity, one write and one read port
module eq_gain_regfile #(
    parameter int NBANDS    = 8,
    parameter int DW        = eq_pkg::DW,
    parameter int GAIN_FRAC = eq_pkg::GAIN_FRAC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_we,
    input  logic [$clog2(NBANDS)-1:0]   i_waddr,
    input  logic [DW-1:0]               i_wdata,
    input  logic [$clog2(NBANDS)-1:0]   i_raddr,
    output logic signed [DW-1:0]        o_rdata
);
    import eq_pkg::*;

    localparam logic [DW-1:0] RESET_GAIN = DW'(1) << GAIN_FRAC;

    logic [DW-1:0] r_gain [NBANDS];
    logic          w_addr_ok;

    // Addresses past the last band exist only when NBANDS is not a power of two; drop them.
    assign w_addr_ok = (int'(i_waddr) < NBANDS);

    // Gain storage: unity after reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBANDS; i++) begin
                r_gain[i] <= RESET_GAIN;
            end
        end else if (i_we && w_addr_ok) begin
            r_gain[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_gain[i_raddr];

endmodule

// File: rtl/eq_band_sequencer.sv
// rtl/eq_band_sequencer.sv - per-sample band scheduler and gain mixer; optional bypass via EQ_SEQ_BYPASS_EN
module eq_band_sequencer #(
    parameter int NBANDS    = 8,
    parameter int DW        = eq_pkg::DW,
    parameter int GAIN_FRAC = eq_pkg::GAIN_FRAC,
    parameter int WAIT_MAX  = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        sample_valid,
    input  logic [DW-1:0]               sample_in,
    input  logic                        gain_we,
    input  logic [$clog2(NBANDS)-1:0]   gain_addr,
    input  logic [DW-1:0]               gain_data,
    output logic                        filt_start,
    output logic [$clog2(NBANDS)-1:0]   filt_band,
    output logic [DW-1:0]               filt_in,
    input  logic                        filt_done,
    input  logic [DW-1:0]               filt_out,
    input  logic                        dacfifo_full,
`ifdef EQ_SEQ_BYPASS_EN
    input  logic                        bypass,
`endif
    output logic                        dacfifo_write,
    output logic [DW-1:0]               eq_out,
    output logic                        busy,
    output logic                        overrun,
    output logic                        timeout
);
    import eq_pkg::*;

    localparam int AW    = $clog2(NBANDS);
    localparam int ACC_W = 2*DW + AW;
    localparam int CW    = $clog2(WAIT_MAX + 1);

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_filt_start;
    logic [AW-1:0]              r_band;
    logic [DW-1:0]              r_filt_in;
    logic signed [DW-1:0]       r_band_out;
    logic [CW-1:0]              r_wait_cnt;
    logic signed [ACC_W-1:0]    r_acc;
    logic [DW-1:0]              r_eq_out;
    logic                       r_overrun;
    logic                       r_timeout;

    logic                       w_bypass;
    logic                       w_fifo_write;
    logic                       w_wait_expired;
    logic                       w_last_band;
    logic signed [DW-1:0]       w_gain;
    logic signed [2*DW-1:0]     w_product;
    logic signed [ACC_W-1:0]    w_product_ext;
    logic signed [63:0]         w_acc_ext;
    logic signed [63:0]         w_acc_shifted;
    logic signed [DW-1:0]       w_sat;

`ifdef EQ_SEQ_BYPASS_EN
    assign w_bypass = bypass;
`else
    assign w_bypass = 1'b0;
`endif

    eq_gain_regfile #(
        .NBANDS    (NBANDS),
        .DW        (DW),
        .GAIN_FRAC (GAIN_FRAC)
    ) u_gain_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (gain_we),
        .i_waddr (gain_addr),
        .i_wdata (gain_data),
        .i_raddr (r_band),
        .o_rdata (w_gain)
    );

    // The last allowed WAIT cycle without a done is treated as a timed-out band.
    assign w_wait_expired = (r_state == WAIT) && !filt_done && (r_wait_cnt == CW'(WAIT_MAX - 1));
    assign w_last_band    = (r_band == AW'(NBANDS - 1));

    // Full-precision product, sign-extended to accumulator width; no saturation until OUT.
    assign w_product     = r_band_out * w_gain;
    assign w_product_ext = {{(ACC_W-2*DW){w_product[2*DW-1]}}, w_product};

    // Arithmetic shift drops the gain fraction (floor), then clamp to the sample range.
    assign w_acc_ext     = {{(64-ACC_W){r_acc[ACC_W-1]}}, r_acc};
    assign w_acc_shifted = w_acc_ext >>> GAIN_FRAC;
    assign w_sat         = saturate(w_acc_shifted);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and FIFO push strobe.
    always_comb begin
        w_state_next = r_state;
        w_fifo_write = 1'b0;
        case (r_state)
            IDLE: begin
                if (sample_valid) begin
                    w_state_next = w_bypass ? WRITE : START;
                end
            end
            START: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                if (filt_done || w_wait_expired) begin
                    w_state_next = MAC;
                end
            end
            MAC: begin
                w_state_next = w_last_band ? OUT : START;
            end
            OUT: begin
                w_state_next = WRITE;
            end
            WRITE: begin
                if (!dacfifo_full) begin
                    w_fifo_write = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: sample latch, band counter, wait timer, accumulator, result and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_start <= 1'b0;
            r_band       <= '0;
            r_filt_in    <= '0;
            r_band_out   <= '0;
            r_wait_cnt   <= '0;
            r_acc        <= '0;
            r_eq_out     <= '0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_filt_start <= (w_state_next == START);

            if (sample_valid && (r_state != IDLE)) begin
                r_overrun <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (sample_valid) begin
                        r_filt_in <= sample_in;
                        r_acc     <= '0;
                        r_band    <= '0;
                        if (w_bypass) begin
                            r_eq_out <= sample_in;
                        end
                    end
                end
                START: begin
                    r_wait_cnt <= '0;
                end
                WAIT: begin
                    if (filt_done) begin
                        r_band_out <= filt_out;
                    end else if (w_wait_expired) begin
                        r_band_out <= '0;
                        r_timeout  <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                MAC: begin
                    r_acc <= r_acc + w_product_ext;
                    if (!w_last_band) begin
                        r_band <= r_band + AW'(1);
                    end
                end
                OUT: begin
                    r_eq_out <= w_sat;
                end
                default: begin
                end
            endcase
        end
    end

    assign filt_start    = r_filt_start;
    assign filt_band     = r_band;
    assign filt_in       = r_filt_in;
    assign dacfifo_write = w_fifo_write;
    assign eq_out        = r_eq_out;
    assign busy          = (r_state != IDLE);
    assign overrun       = r_overrun;
    assign timeout       = r_timeout;

endmodule

// File: tb/tb_eq_band_sequencer.sv
// tb/tb_eq_band_sequencer.sv - self-checking bench for eq_band_sequencer
module tb_eq_band_sequencer;

    localparam int NB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_valid;
    logic [15:0] sample_in;
    logic        gain_we;
    logic [2:0]  gain_addr;
    logic [15:0] gain_data;
    logic        filt_start;
    logic [2:0]  filt_band;
    logic [15:0] filt_in;
    logic        filt_done;
    logic [15:0] filt_out;
    logic        dacfifo_full;
    logic        bypass;
    logic        dacfifo_write;
    logic [15:0] eq_out;
    logic        busy;
    logic        overrun;
    logic        timeout;

    always #5 clk = ~clk;

    eq_band_sequencer #(.NBANDS(NB), .DW(16), .GAIN_FRAC(14), .WAIT_MAX(255)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_valid  (sample_valid),
        .sample_in     (sample_in),
        .gain_we       (gain_we),
        .gain_addr     (gain_addr),
        .gain_data     (gain_data),
        .filt_start    (filt_start),
        .filt_band     (filt_band),
        .filt_in       (filt_in),
        .filt_done     (filt_done),
        .filt_out      (filt_out),
        .dacfifo_full  (dacfifo_full),
`ifdef EQ_SEQ_BYPASS_EN
        .bypass        (bypass),
`endif
        .dacfifo_write (dacfifo_write),
        .eq_out        (eq_out),
        .busy          (busy),
        .overrun       (overrun),
        .timeout       (timeout)
    );

    typedef struct {
        logic [15:0] sample;
        logic [15:0] fval;
        logic [15:0] gain;
        logic [15:0] exp;
    } vec_t;

    vec_t        vecs [12];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q [$];
    int          push_cnt = 0;
    int          band_log [$];
    logic signed [15:0] core_val [NB];
    bit          core_drop [NB];
    logic signed [15:0] m_gain [NB];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every push is compared against the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (dacfifo_write === 1'b1) begin
                push_cnt++;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_push: got eq_out %0h with no expectation", eq_out);
                end else begin
                    check("eq_out", {48'd0, eq_out}, {48'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Filter core model: done two cycles after start, unless the band is marked as dropped.
    initial begin
        int b;
        filt_done = 1'b0;
        filt_out  = 16'h0;
        forever begin
            @(negedge clk);
            if (filt_start === 1'b1 && rst_n === 1'b1) begin
                b = int'(filt_band);
                band_log.push_back(b);
                if (!core_drop[b]) begin
                    repeat (2) @(negedge clk);
                    if (rst_n === 1'b1) begin
                        filt_done = 1'b1;
                        filt_out  = core_val[b];
                        @(negedge clk);
                        filt_done = 1'b0;
                        filt_out  = 16'h5A5A;
                    end
                end
            end
        end
    end

    task automatic write_gain(input int a, input logic [15:0] d);
        @(negedge clk);
        gain_we   = 1'b1;
        gain_addr = 3'(a);
        gain_data = d;
        @(negedge clk);
        gain_we   = 1'b0;
    endtask

    task automatic all_gains(input logic [15:0] d);
        for (int b = 0; b < NB; b++) write_gain(b, d);
    endtask

    task automatic set_core(input logic [15:0] v);
        for (int b = 0; b < NB; b++) core_val[b] = v;
    endtask

    task automatic send_raw(input logic [15:0] s);
        @(negedge clk);
        sample_valid = 1'b1;
        sample_in    = s;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [15:0] s, input logic [15:0] exp);
        exp_q.push_back(exp);
        send_raw(s);
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((busy === 1'b1 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: no result within %0d cycles", name, budget);
            exp_q.delete();
        end
    endtask

    task automatic wait_starts(input int cnt, input int budget);
        int n = 0;
        while (band_log.size() < cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            n_cmp++;
            n_err++;
            $display("FAIL start_wait: saw %0d starts, wanted %0d", band_log.size(), cnt);
        end
    endtask

    function automatic logic [15:0] model_mix();
        longint acc = 0;
        for (int b = 0; b < NB; b++) acc += longint'(m_gain[b]) * longint'(core_val[b]);
        acc = acc >>> 14;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc[15:0];
    endfunction

    initial begin
        int pc;
        int bad;
        vecs[0]  = '{16'd123,  16'd1000,  16'h4000, 16'd8000};
        vecs[1]  = '{16'd1,    16'h7FFF,  16'h7FFF, 16'h7FFF};
        vecs[2]  = '{16'd2,    16'h8000,  16'h7FFF, 16'h8000};
        vecs[3]  = '{16'd3,    16'hFF9C,  16'h2000, 16'hFE70};
        vecs[4]  = '{16'd4,    16'd3,     16'h4000, 16'd24};
        vecs[5]  = '{16'd5,    16'hFFFF,  16'h0001, 16'hFFFF};
        vecs[6]  = '{16'd6,    16'h0001,  16'h0001, 16'h0000};
        vecs[7]  = '{16'd7,    16'd4096,  16'h4000, 16'h7FFF};
        vecs[8]  = '{16'd8,    16'd4095,  16'h4000, 16'h7FF8};
        vecs[9]  = '{16'd9,    16'hF000,  16'h4000, 16'h8000};
        vecs[10] = '{16'd10,   16'h7FFF,  16'h8000, 16'h8000};
        vecs[11] = '{16'd11,   16'h8000,  16'h8000, 16'h7FFF};

        rst_n = 1'b0; sample_valid = 1'b0; sample_in = '0; gain_we = 1'b0;
        gain_addr = '0; gain_data = '0; dacfifo_full = 1'b0; bypass = 1'b0;
        for (int b = 0; b < NB; b++) begin core_val[b] = 16'sd0; core_drop[b] = 1'b0; end
        repeat (3) @(negedge clk);
        check("reset_outputs", {filt_start, filt_band, filt_in, dacfifo_write, eq_out, busy, overrun, timeout}, 64'd0);
        rst_n = 1'b1;

        // Unity gains straight out of reset, band order and single push.
        set_core(16'd1000);
        send_sample(16'd123, 16'd8000);
        wait_done("unity", 200);
        check("band_count", band_log.size(), 8);
        bad = 0;
        for (int i = 0; i < band_log.size(); i++) if (band_log[i] != i) bad++;
        check("band_order", bad, 0);
        check("filt_in_latched", filt_in, 16'd123);
        check("push_count", push_cnt, 1);

        // Table of uniform gain/output patterns.
        for (int v = 0; v < 12; v++) begin
            all_gains(vecs[v].gain);
            set_core(vecs[v].fval);
            send_sample(vecs[v].sample, vecs[v].exp);
            wait_done("vector", 200);
        end

        // Distinct per-band gains and outputs.
        for (int b = 0; b < NB; b++) begin
            m_gain[b]   = 16'(b * 16'h0900 - 16'h1800);
            core_val[b] = 16'(b * 977 - 3000);
            write_gain(b, m_gain[b]);
        end
        send_sample(16'd55, model_mix());
        wait_done("mixed", 200);

        // FIFO full holds the result at WRITE.
        all_gains(16'h4000);
        set_core(16'd1000);
        band_log.delete();
        pc = push_cnt;
        dacfifo_full = 1'b1;
        send_sample(16'd5, 16'd8000);
        wait_starts(8, 200);
        repeat (8) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dacfifo_write !== 1'b0 || eq_out !== 16'd8000) bad++;
        end
        check("full_hold", bad, 0);
        check("full_busy", busy, 1);
        @(posedge clk);
        #1 dacfifo_full = 1'b0;
        @(negedge clk);
        check("push_on_release", dacfifo_write, 1);
        wait_done("full_release", 20);
        check("full_push_count", push_cnt - pc, 1);

        // Second sample during WAIT is dropped and flagged.
        band_log.delete();
        pc = push_cnt;
        check("overrun_clear", overrun, 0);
        send_sample(16'd77, 16'd8000);
        wait_starts(3, 200);
        send_raw(16'd999);
        check("overrun_set", overrun, 1);
        wait_done("overrun", 200);
        check("overrun_push_count", push_cnt - pc, 1);
        check("overrun_filt_in", filt_in, 16'd77);

        // Band 3 never answers.
        band_log.delete();
        for (int b = 0; b < NB; b++) core_val[b] = 16'(100 * (b + 1));
        core_drop[3] = 1'b1;
        check("timeout_clear", timeout, 0);
        send_sample(16'd9, 16'd3200);
        wait_done("timeout", 800);
        core_drop[3] = 1'b0;
        check("timeout_set", timeout, 1);
        check("timeout_bands", band_log.size(), 8);

        // Reset during band 5 WAIT aborts without a push and restores unity gains.
        write_gain(0, 16'h2000);
        set_core(16'd1000);
        band_log.delete();
        pc = push_cnt;
        send_raw(16'd33);
        wait_starts(6, 200);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {filt_start, filt_band, filt_in, dacfifo_write, eq_out, busy, overrun, timeout}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_push", push_cnt - pc, 0);
        band_log.delete();
        send_sample(16'd1, 16'd8000);
        wait_done("post_reset_unity", 200);

`ifdef EQ_SEQ_BYPASS_EN
        band_log.delete();
        bypass = 1'b1;
        send_sample(16'h1234, 16'h1234);
        wait_done("bypass", 20);
        bypass = 1'b0;
        check("bypass_no_start", band_log.size(), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
